// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch: 256x16 program memory, 2-entry fetch FIFO, IDLE/RUN/HALT control
module instruction_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  address,
  input  logic        flush,
  input  logic        start,
  input  logic        prog_we,
  input  logic [7:0]  prog_adr,
  input  logic [15:0] prog_data,
  input  logic        decode_ready,
  output logic [15:0] instr,
  output logic [7:0]  instr_adr,
  output logic        instr_valid,
  output logic        pc_stall,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state, state_nx;
  logic [15:0] mem [0:255];
  logic [15:0] rd_data;
  logic [7:0]  rd_adr;
  logic        inflight;
  logic [15:0] e0_data, e1_data;
  logic [7:0]  e0_adr, e1_adr;
  logic [1:0]  count;
  logic        issue, push, pop, halt_push;
  logic [2:0]  occupancy;

  always_comb begin
    pop       = instr_valid & decode_ready;
    push      = inflight & ~flush;
    halt_push = push & (state == RUN) & (rd_data == 16'hFFFF);
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    // The halt word stops fetching in the cycle it lands, so nothing past it is read.
    pc_stall = 1'b1;
    if (state == RUN) begin
      if (flush)
        pc_stall = 1'b0;
      else if (halt_push)
        pc_stall = 1'b1;
      else
        pc_stall = (occupancy >= 3'd2);
    end
    issue = (state == RUN) & ~pc_stall & ~flush;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (halt_push) state_nx = HALT;
      default: state_nx = state;
    endcase
  end

  // Memory has no reset so its contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (!reset && prog_we && state == IDLE)
      mem[prog_adr] <= prog_data;
    if (issue) begin
      rd_data <= mem[address];
      rd_adr  <= address;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      inflight <= 1'b0;
      count    <= 2'd0;
      e0_data  <= 16'h0000;
      e0_adr   <= 8'h00;
      e1_data  <= 16'h0000;
      e1_adr   <= 8'h00;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (flush) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b11: begin
            if (count == 2'd1) begin
              e0_data <= rd_data;
              e0_adr  <= rd_adr;
            end else begin
              e0_data <= e1_data;
              e0_adr  <= e1_adr;
              e1_data <= rd_data;
              e1_adr  <= rd_adr;
            end
          end
          2'b10: begin
            if (count == 2'd0) begin
              e0_data <= rd_data;
              e0_adr  <= rd_adr;
            end else begin
              e1_data <= rd_data;
              e1_adr  <= rd_adr;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            e0_data <= e1_data;
            e0_adr  <= e1_adr;
            count   <= count - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign instr       = e0_data;
  assign instr_adr   = e0_adr;
  assign instr_valid = (count != 2'd0);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, flush, start, prog_we, decode_ready;
  logic [7:0]  address, prog_adr;
  logic [15:0] prog_data;
  logic [15:0] instr;
  logic [7:0]  instr_adr;
  logic        instr_valid, pc_stall, halted;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .address(address), .flush(flush), .start(start),
    .prog_we(prog_we), .prog_adr(prog_adr), .prog_data(prog_data),
    .decode_ready(decode_ready), .instr(instr), .instr_adr(instr_adr),
    .instr_valid(instr_valid), .pc_stall(pc_stall), .halted(halted)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] mem_model [256];
  logic [23:0] exp_q [$];
  logic [7:0]  pc = 8'h00;
  logic [7:0]  target = 8'h00;
  logic [7:0]  target_l = 8'h00;
  logic        stall_l = 1'b1;
  logic        flush_l = 1'b0;
  logic        reset_l = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected delivery: program order from the restart point up to and including a halt word.
  task automatic queue_from(input logic [7:0] a);
    logic [7:0] x;
    x = a;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({mem_model[x], x});
      if (mem_model[x] == 16'hFFFF) break;
      x = x + 8'd1;
    end
  endtask

  // Program counter of the surrounding pipeline, advanced at the edge just passed.
  task automatic tick();
    @(negedge clk);
    if (reset_l)      pc = 8'h00;
    else if (flush_l) pc = target_l;
    else if (!stall_l) pc = pc + 8'd1;
    address  = pc;
    flush    = 1'b0;
    start    = 1'b0;
    prog_we  = 1'b0;
  endtask

  task automatic commit();
    #1;
    stall_l  = pc_stall;
    flush_l  = flush;
    reset_l  = reset;
    target_l = target;
  endtask

  task automatic check_reset_values();
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_adr", instr_adr, 0);
    check("rst_pc_stall", pc_stall, 1);
    check("rst_halted", halted, 0);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    decode_ready = 1'b0;
    exp_q.delete();
    commit();
    tick();
    check_reset_values();
    reset = 1'b0;
    commit();
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    tick();
    prog_we   = 1'b1;
    prog_adr  = a;
    prog_data = d;
    mem_model[a] = d;
    commit();
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'hFFFF) w = 16'h0F0F;
    return w;
  endfunction

  // mode 0 random, 1 full-rate no flush, 2 flush at pc 05 to 80, 3 stall then reset, 4 random ready no flush
  task automatic run(input int mode);
    int  cyc;
    bit  flushed;
    flushed = 0;
    tick();
    start = 1'b1;
    decode_ready = 1'b1;
    queue_from(8'h00);
    commit();
    tick();
    for (cyc = 0; cyc < 400; cyc++) begin
      if (halted && exp_q.size() == 0) break;
      if (mode == 1 && cyc >= 2 && cyc <= 6) check("throughput_valid", instr_valid, 1);
      if (mode == 3 && cyc == 8) begin
        check("full_valid", instr_valid, 1);
        check("full_pc_stall", pc_stall, 1);
        reset = 1'b1;
        exp_q.delete();
        commit();
        tick();
        check_reset_values();
        reset = 1'b0;
        commit();
        return;
      end
      if (mode == 1 || mode == 2) decode_ready = 1'b1;
      else if (mode == 3)         decode_ready = 1'b0;
      else                        decode_ready = ($urandom_range(0, 9) < 7);
      if (mode == 0 && !halted && $urandom_range(0, 19) == 0) begin
        flush  = 1'b1;
        target = 8'($urandom);
      end
      if (mode == 2 && !halted && !flushed && pc == 8'h05) begin
        flush   = 1'b1;
        target  = 8'h80;
        flushed = 1;
      end
      if (flush) queue_from(target);
      if (mode != 1 && $urandom_range(0, 3) == 0) begin
        prog_we   = 1'b1;
        prog_adr  = 8'($urandom_range(0, 15));
        prog_data = 16'($urandom);
      end
      commit();
      tick();
    end
    check("run_bound", (cyc < 400), 1);
    check("halted", halted, 1);
    check("halt_pc_stall", pc_stall, 1);
    check("drained", exp_q.size(), 0);
    if (mode == 2) check("flush_taken", flushed, 1);
    decode_ready = 1'b1;
    commit();
    tick();
    check("halt_no_more", instr_valid, 0);
    check("halt_stays", halted, 1);
    commit();
  endtask

  // Monitor: samples once per cycle after the driver has settled the inputs.
  initial begin : monitor
    int          since;
    bit          hold_prev;
    logic [23:0] prev, e;
    since = -1;
    hold_prev = 0;
    prev = 24'h0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        since = -1;
        hold_prev = 0;
      end else begin
        if (hold_prev && instr_valid) check("hold_stable", {instr, instr_adr}, prev);
        if (flush || start) begin
          since = 0;
        end else if (since >= 0) begin
          since++;
          if (since < 3) begin
            check("startup_gap", instr_valid, 0);
          end else begin
            check("first_valid_latency", instr_valid, 1);
            since = -1;
          end
        end
        if (instr_valid && decode_ready && !flush) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", {instr, instr_adr}, 24'hxxxxxx);
          end else begin
            e = exp_q.pop_front();
            check("instr_word", {instr, instr_adr}, e);
          end
        end
        hold_prev = instr_valid && !decode_ready && !flush;
        prev = {instr, instr_adr};
      end
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; start = 1'b0; prog_we = 1'b0; decode_ready = 1'b0;
    address = 8'h00; prog_adr = 8'h00; prog_data = 16'h0000;
    do_reset();
    for (int a = 0; a < 256; a++)
      load(8'(a), (a % 16 == 15) ? 16'hFFFF : rand_word());
    load(8'h00, 16'h1111);
    load(8'h01, 16'h2222);
    load(8'h02, 16'h3333);
    load(8'h03, 16'h4444);
    load(8'h04, 16'hFFFF);
    run(1);
    do_reset();
    load(8'h04, rand_word());
    load(8'h80, 16'hABCD);
    run(2);
    do_reset();
    run(3);
    load(8'h02, 16'hFFFF);
    run(4);
    do_reset();
    load(8'h02, rand_word());
    for (int r = 0; r < 8; r++) begin
      run(0);
      do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
